// File: rtl/neuron_mac_acc_pkg.sv
// Shared widths and pipeline-control types for the neuron MAC/accumulate slice.
package neuron_mac_acc_pkg;

  // Control bits that travel alongside a beat's products through the pipe.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_ctl_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned prod_width(input int unsigned din_w,
                                             input int unsigned weight_w);
    return din_w + weight_w;
  endfunction

  // Wide enough that VECTOR_LEN worst-case products can never wrap.
  function automatic int unsigned acc_width(input int unsigned din_w,
                                            input int unsigned weight_w,
                                            input int unsigned vector_len);
    return prod_width(din_w, weight_w) + clog2(vector_len);
  endfunction

endpackage

// File: rtl/neuron_mac_acc_if.sv
// Beat-input / sum-output bundle between the MAC stage and its neighbours.
interface neuron_mac_acc_if #(
  parameter int unsigned PARALLEL_IN  = 4,
  parameter int unsigned DIN_WIDTH    = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned DOUT_WIDTH   = 32
);

  logic [PARALLEL_IN*DIN_WIDTH-1:0]    din;
  logic [PARALLEL_IN*WEIGHT_WIDTH-1:0] weight;
  logic                                din_valid;
  logic                                sync_clr;
  logic [PARALLEL_IN*DOUT_WIDTH-1:0]   dout;
  logic                                dout_valid;
  logic [PARALLEL_IN-1:0]              sat;

  modport master (
    output din,
    output weight,
    output din_valid,
    output sync_clr,
    input  dout,
    input  dout_valid,
    input  sat
  );

  modport slave (
    input  din,
    input  weight,
    input  din_valid,
    input  sync_clr,
    output dout,
    output dout_valid,
    output sat
  );

endinterface

// File: rtl/neuron_mac_acc_lane.sv
// One neuron lane: signed product register, non-wrapping accumulator and
// saturating output register.
module neuron_mac_lane
  import neuron_mac_acc_pkg::*;
#(
  parameter int unsigned DIN_WIDTH    = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned DOUT_WIDTH   = 32,
  parameter int unsigned VECTOR_LEN   = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [DIN_WIDTH-1:0]    din_i,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_i,
  input  logic                           prod_en_i,
  input  logic                           acc_en_i,
  input  logic                           acc_first_i,
  input  logic                           out_en_i,
  output logic [DOUT_WIDTH-1:0]          dout_o,
  output logic                           sat_o
);

  localparam int unsigned PROD_W = prod_width(DIN_WIDTH, WEIGHT_WIDTH);
  localparam int unsigned ACC_W  = acc_width(DIN_WIDTH, WEIGHT_WIDTH, VECTOR_LEN);
  // Saturation compares are done at max(ACC_W, DOUT_WIDTH) so narrow
  // accumulators still sign-extend cleanly into the output width.
  localparam int unsigned EXT_W  = (ACC_W > DOUT_WIDTH) ? ACC_W : DOUT_WIDTH;

  localparam logic signed [EXT_W-1:0] SAT_HI =
    {{(EXT_W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_LO =
    {{(EXT_W-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [DOUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic signed [EXT_W-1:0]  acc_ext;
  logic [DOUT_WIDTH-1:0]    dout_d, dout_q;
  logic                     sat_d, sat_q;

  always_comb begin
    prod_d = PROD_W'(din_i) * PROD_W'(weight_i);
  end

  // Loading on the first beat lets a new vector follow the previous
  // one's last beat with no flush cycle in between.
  always_comb begin
    acc_d = acc_q;
    if (acc_en_i) begin
      if (acc_first_i) acc_d = ACC_W'(prod_q);
      else             acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_comb begin
    acc_ext = EXT_W'(acc_q);
    dout_d  = acc_ext[DOUT_WIDTH-1:0];
    sat_d   = 1'b0;
    if (acc_ext > SAT_HI) begin
      dout_d = OUT_MAX;
      sat_d  = 1'b1;
    end else if (acc_ext < SAT_LO) begin
      dout_d = OUT_MIN;
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (prod_en_i) prod_q <= prod_d;
      acc_q <= acc_d;
      if (out_en_i) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign dout_o = dout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/neuron_mac_acc.sv
// Parallel signed multiply-accumulate stage: beat counter, valid/first/last
// pipeline and abort handling shared by PARALLEL_IN independent lanes.
module neuron_mac_acc
  import neuron_mac_acc_pkg::*;
#(
  parameter int unsigned PARALLEL_IN  = 4,
  parameter int unsigned DIN_WIDTH    = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned DOUT_WIDTH   = 32,
  parameter int unsigned VECTOR_LEN   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  neuron_mac_acc_if.slave  bus
);

  localparam int unsigned     CNT_W     = clog2(VECTOR_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECTOR_LEN - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  beat_ctl_t        s1_d, s1_q;
  logic             s2_last_d, s2_last_q;
  logic             dout_valid_d, dout_valid_q;
  logic             beat_en;
  logic             acc_en;
  logic             out_en;

  logic [PARALLEL_IN*DOUT_WIDTH-1:0] dout_w;
  logic [PARALLEL_IN-1:0]            sat_w;

  // sync_clr overrides a coincident beat and drops whatever is in S1/S2.
  always_comb begin
    beat_en = bus.din_valid & ~bus.sync_clr;
    acc_en  = s1_q.valid & ~bus.sync_clr;
    out_en  = s2_last_q & ~bus.sync_clr;

    cnt_d = cnt_q;
    if (bus.sync_clr)          cnt_d = '0;
    else if (bus.din_valid)    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;

    s1_d.valid = beat_en;
    s1_d.first = (cnt_q == '0);
    s1_d.last  = (cnt_q == LAST_BEAT);

    s2_last_d    = acc_en & s1_q.last;
    dout_valid_d = out_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      s1_q         <= '0;
      s2_last_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_last_q    <= s2_last_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  for (genvar i = 0; i < PARALLEL_IN; i++) begin : g_lane
    neuron_mac_lane #(
      .DIN_WIDTH    (DIN_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .DOUT_WIDTH   (DOUT_WIDTH),
      .VECTOR_LEN   (VECTOR_LEN)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .din_i       (bus.din[i*DIN_WIDTH +: DIN_WIDTH]),
      .weight_i    (bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .prod_en_i   (beat_en),
      .acc_en_i    (acc_en),
      .acc_first_i (s1_q.first),
      .out_en_i    (out_en),
      .dout_o      (dout_w[i*DOUT_WIDTH +: DOUT_WIDTH]),
      .sat_o       (sat_w[i])
    );
  end

  assign bus.dout       = dout_w;
  assign bus.sat        = sat_w;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc (4 lanes, 16x16 -> 32, VECTOR_LEN=4)
// with a per-cycle reference model of dot products, saturation and aborts.
module tb_neuron_mac_acc;

  localparam int VLEN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_acc_if #(
    .PARALLEL_IN  (4),
    .DIN_WIDTH    (16),
    .WEIGHT_WIDTH (16),
    .DOUT_WIDTH   (32)
  ) bus ();

  neuron_mac_acc #(
    .PARALLEL_IN  (4),
    .DIN_WIDTH    (16),
    .WEIGHT_WIDTH (16),
    .DOUT_WIDTH   (32),
    .VECTOR_LEN   (VLEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int pulses = 0;
  int mcnt   = 0;

  typedef struct {
    int           due;
    logic [127:0] d;
    logic [3:0]   s;
  } exp_t;

  exp_t         pend[$];
  longint       msum[4];
  logic [127:0] exp_dout = '0;
  logic [3:0]   exp_sat  = '0;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [63:0] pk(input int a0, input int a1,
                                     input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Reference model: one dot product per VECTOR_LEN accepted beats, result
  // visible 3 cycles after the beat's cycle; an abort or reset kills any
  // result not yet visible.
  always @(negedge clk) begin
    logic   ev;
    longint p;
    exp_t   e;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      mcnt     = 0;
      exp_dout = '0;
      exp_sat  = '0;
      chk("rst_dout_valid", 128'(bus.dout_valid), 128'(0));
      chk("rst_dout", bus.dout, '0);
      chk("rst_sat", 128'(bus.sat), 128'(0));
    end else begin
      ev = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ev       = 1'b1;
        exp_dout = pend[0].d;
        exp_sat  = pend[0].s;
        void'(pend.pop_front());
      end
      chk("dout_valid", 128'(bus.dout_valid), 128'(ev));
      chk("dout", bus.dout, exp_dout);
      chk("sat", 128'(bus.sat), 128'(exp_sat));
      if (ev) pulses++;

      if (bus.sync_clr) begin
        mcnt = 0;
        pend.delete();
      end else if (bus.din_valid) begin
        for (int i = 0; i < 4; i++) begin
          p = longint'($signed(bus.din[i*16 +: 16])) *
              longint'($signed(bus.weight[i*16 +: 16]));
          msum[i] = (mcnt == 0) ? p : msum[i] + p;
        end
        mcnt++;
        if (mcnt == VLEN) begin
          mcnt  = 0;
          e.due = cyc + 3;
          for (int i = 0; i < 4; i++) begin
            if (msum[i] > 64'sd2147483647) begin
              e.d[i*32 +: 32] = 32'h7FFF_FFFF;
              e.s[i]          = 1'b1;
            end else if (msum[i] < -64'sd2147483648) begin
              e.d[i*32 +: 32] = 32'h8000_0000;
              e.s[i]          = 1'b1;
            end else begin
              e.d[i*32 +: 32] = msum[i][31:0];
              e.s[i]          = 1'b0;
            end
          end
          pend.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    bus.sync_clr  = 1'b0;
    repeat (n) step();
  endtask

  task automatic beat(input logic [63:0] d, input logic [63:0] w);
    bus.din       = d;
    bus.weight    = w;
    bus.din_valid = 1'b1;
    bus.sync_clr  = 1'b0;
    step();
    bus.din_valid = 1'b0;
  endtask

  task automatic clr(input logic with_beat);
    bus.sync_clr  = 1'b1;
    bus.din_valid = with_beat;
    step();
    bus.sync_clr  = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  task automatic pin(input string nm, input int i, input logic [31:0] v,
                     input logic s);
    chk({nm, "_dut"}, 128'(bus.dout[i*32 +: 32]), 128'(v));
    chk({nm, "_model"}, 128'(exp_dout[i*32 +: 32]), 128'(v));
    chk({nm, "_sat_dut"}, 128'(bus.sat[i]), 128'(s));
    chk({nm, "_sat_model"}, 128'(exp_sat[i]), 128'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int gap_a[4];
    gap_a = '{2, 0, 1, 0};

    bus.din       = '0;
    bus.weight    = '0;
    bus.din_valid = 1'b0;
    bus.sync_clr  = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic and signed lanes: 1+2+3+4, -3*5*4, zero lane, 7*-2*4.
    for (int b = 1; b <= 4; b++) beat(pk(b, -3, 0, 7), pk(1, 5, 9, -2));
    idle(5);
    pin("basic_l0", 0, 32'd10, 1'b0);
    pin("signed_l1", 1, -32'sd60, 1'b0);
    pin("zero_l2", 2, 32'd0, 1'b0);
    pin("signed_l3", 3, -32'sd56, 1'b0);

    // Deep saturation both ways.
    for (int b = 0; b < 4; b++)
      beat(pk(-32768, -32768, 32767, 1000), pk(-32768, 32767, 32767, 1000));
    idle(5);
    pin("sat_pos", 0, 32'h7FFF_FFFF, 1'b1);
    pin("sat_neg", 1, 32'h8000_0000, 1'b1);
    pin("sat_pos2", 2, 32'h7FFF_FFFF, 1'b1);
    pin("nosat", 3, 32'd4000000, 1'b0);

    // Exactly at and one past each limit.
    beat(pk(32767, 32767, -32768, -32768), pk(32767, 32767, 32767, 32767));
    beat(pk(32767, 32767, -32768, -32768), pk(32767, 32767, 32767, 32767));
    beat(pk(32767, 32767, -32768, -32768), pk(4, 4, 2, 2));
    beat(pk(1, 1, 0, -1), pk(1, 2, 0, 1));
    idle(5);
    pin("at_max", 0, 32'h7FFF_FFFF, 1'b0);
    pin("over_max", 1, 32'h7FFF_FFFF, 1'b1);
    pin("at_min", 2, 32'h8000_0000, 1'b0);
    pin("under_min", 3, 32'h8000_0000, 1'b1);

    // Vector A with gaps, B immediately after A's last beat.
    p0 = pulses;
    for (int b = 0; b < 4; b++) begin
      beat(pk(b + 1, 2*b - 3, 100*b, b - 50), pk(3, -7, 11, 2));
      idle(gap_a[b]);
    end
    for (int b = 0; b < 4; b++)
      beat(pk(-(b + 2), b*b, 30, -1000), pk(7, 7, -9, b));
    idle(5);
    chk("b2b_pulses", 128'(pulses - p0), 128'(2));
    pin("b2b_l0", 0, -32'sd98, 1'b0);
    pin("b2b_l2", 2, -32'sd1080, 1'b0);

    // Abort mid-vector, then a clean vector of ones.
    p0 = pulses;
    beat(pk(100, 100, 100, 100), pk(1, 1, 1, 1));
    beat(pk(100, 100, 100, 100), pk(1, 1, 1, 1));
    clr(1'b0);
    for (int b = 0; b < 4; b++) beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    idle(5);
    chk("clr_pulses", 128'(pulses - p0), 128'(1));
    pin("clr_l0", 0, 32'd4, 1'b0);

    // Abort coinciding with a beat: that beat is dropped.
    beat(pk(100, 100, 100, 100), pk(1, 1, 1, 1));
    beat(pk(100, 100, 100, 100), pk(1, 1, 1, 1));
    bus.din = pk(100, 100, 100, 100);
    clr(1'b1);
    for (int b = 0; b < 4; b++) beat(pk(1, 1, 1, 1), pk(2, 2, 2, 2));
    idle(5);
    pin("clr_beat_l0", 0, 32'd8, 1'b0);

    // Aborts landing while the finished sum is still in S1 or S2.
    p0 = pulses;
    for (int b = 0; b < 4; b++) beat(pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    clr(1'b0);
    for (int b = 0; b < 4; b++) beat(pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    idle(1);
    clr(1'b0);
    idle(5);
    chk("kill_pulses", 128'(pulses - p0), 128'(0));
    pin("kill_hold", 0, 32'd8, 1'b0);

    // Abort once the sum has already reached S3 still delivers it.
    p0 = pulses;
    for (int b = 0; b < 4; b++) beat(pk(3, 3, 3, 3), pk(3, 3, 3, 3));
    idle(2);
    clr(1'b0);
    idle(3);
    chk("late_clr_pulses", 128'(pulses - p0), 128'(1));
    pin("late_clr_l0", 0, 32'd36, 1'b0);

    // Asynchronous reset mid-vector, between clock edges.
    beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5));
    beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", bus.dout, '0);
    chk("async_rst_valid", 128'(bus.dout_valid), 128'(0));
    chk("async_rst_sat", 128'(bus.sat), 128'(0));
    @(posedge clk);
    #1;
    idle(2);
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) beat(pk(2, 2, 2, 2), pk(3, 3, 3, 3));
    idle(5);
    pin("post_rst_l0", 0, 32'd24, 1'b0);
    pin("post_rst_l3", 3, 32'd24, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
